// File: rtl/layer_argmax.sv
// Sequential argmax over one fully-connected layer's ReLU outputs (IEEE-754 single per node).
// Optional build macro LAYER_ARGMAX_NAN_FILTER_EN zeroes Inf/NaN elements before compare and storage.
module layer_argmax #(
  parameter int unsigned N_IN = 21,
  parameter int unsigned IDXW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*N_IN-1:0]   in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      class_idx,
  output logic [31:0]          class_val
);

  localparam int unsigned W = 32;
  localparam logic [IDXW-1:0] LAST = IDXW'(N_IN - 1);
  localparam bit SINGLE = (N_IN == 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [W-1:0]      buf_q [N_IN];
  logic [W-1:0]      best_val;
  logic [IDXW-1:0]   best_idx;
  logic [IDXW-1:0]   ptr;

  logic [W-1:0]      cur;
  logic              cur_gt;

  // Negative values (including -0) and, optionally, Inf/NaN collapse to +0.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x;
    if (x[W-1]) y = '0;
`ifdef LAYER_ARGMAX_NAN_FILTER_EN
    if (x[30:23] == 8'hFF) y = '0;
`endif
    return y;
  endfunction

  // Buffer already holds sanitized non-negative values, so magnitude bits order them.
  assign cur    = buf_q[ptr];
  assign cur_gt = cur[30:0] > best_val[30:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      class_idx <= '0;
      class_val <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      ptr       <= '0;
      for (int unsigned k = 0; k < N_IN; k++) buf_q[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < N_IN; k++) buf_q[k] <= sanitize(in_vec[W*k +: W]);
            best_val <= sanitize(in_vec[W-1:0]);
            best_idx <= '0;
            ptr      <= IDXW'(1);
            in_ready <= 1'b0;
            if (SINGLE) begin
              state     <= DONE;
              out_valid <= 1'b1;
              class_idx <= '0;
              class_val <= sanitize(in_vec[W-1:0]);
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cur_gt) begin
            best_val <= cur;
            best_idx <= ptr;
          end
          ptr <= ptr + IDXW'(1);
          // Publish including the final element's compare so the result lands with out_valid.
          if (ptr == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            class_idx <= cur_gt ? ptr : best_idx;
            class_val <= cur_gt ? cur : best_val;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            ptr       <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
